// File: rtl/ring_osc_trim_seq.sv
// rtl/ring_osc_trim_seq.sv - ring oscillator trim sequencer: start kick, then
// one-count-at-a-time slew of a thermometer trim vector toward a binary target.
module ring_osc_trim_seq #(
  parameter int NSTAGES     = 13,
  parameter int TRIM_LEVELS = 2,
  parameter int KICK_CYCLES = 4,
  parameter int STEP_DIV    = 8,
  localparam int NT         = NSTAGES * TRIM_LEVELS,
  localparam int CW         = $clog2(NT + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] tgt_code,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  output logic          osc_reset,
  output logic [NT-1:0] trim,
  output logic [CW-1:0] cur_code,
  output logic          busy,
  output logic          locked,
  output logic          clamp_err
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int KW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;

  typedef enum logic [1:0] {S_OFF, S_KICK, S_RAMP, S_HOLD} state_t;

  state_t        state;
  logic [CW-1:0] tgt_reg;
  logic [PW-1:0] prescaler;
  logic [KW-1:0] kick_cnt;

  logic          accept;
  logic          over_range;
  logic [CW-1:0] tgt_clamped;
  logic [CW-1:0] tgt_eff;
  logic          step;
  logic [CW-1:0] code_nxt;

  // Bit i is set when i < c, so level 0 fills across all stages before level 1.
  function automatic logic [NT-1:0] therm(input logic [CW-1:0] c);
    logic [NT-1:0] t;
    for (int i = 0; i < NT; i++) begin
      t[i] = (i < int'(c));
    end
    return t;
  endfunction

  // A target arriving on a step edge steers that step, so the ramp can never
  // settle in HOLD against a stale target.
  always_comb begin
    accept      = tgt_valid && tgt_ready;
    over_range  = (tgt_code > CW'(NT));
    tgt_clamped = over_range ? CW'(NT) : tgt_code;
    tgt_eff     = accept ? tgt_clamped : tgt_reg;
    step        = (prescaler == PW'(STEP_DIV - 1));
    code_nxt    = cur_code;
    if (!enable || state == S_OFF || state == S_KICK) begin
      code_nxt = '0;
    end else if (state == S_RAMP && step) begin
      if (cur_code < tgt_eff) begin
        code_nxt = cur_code + CW'(1);
      end else if (cur_code > tgt_eff) begin
        code_nxt = cur_code - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_OFF;
      osc_reset <= 1'b1;
      trim      <= '0;
      cur_code  <= '0;
      tgt_reg   <= '0;
      prescaler <= '0;
      kick_cnt  <= '0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      clamp_err <= 1'b0;
      tgt_ready <= 1'b1;
    end else begin
      cur_code <= code_nxt;
      trim     <= therm(code_nxt);
      if (accept) begin
        tgt_reg <= tgt_clamped;
      end
      if (!enable) begin
        clamp_err <= 1'b0;
      end else if (accept && over_range) begin
        clamp_err <= 1'b1;
      end

      if (!enable) begin
        state     <= S_OFF;
        osc_reset <= 1'b1;
        prescaler <= '0;
        busy      <= 1'b0;
        locked    <= 1'b0;
        tgt_ready <= 1'b1;
      end else begin
        case (state)
          S_OFF: begin
            state     <= S_KICK;
            kick_cnt  <= KW'(KICK_CYCLES - 1);
            osc_reset <= 1'b1;
            busy      <= 1'b1;
            locked    <= 1'b0;
            tgt_ready <= 1'b0;
          end
          S_KICK: begin
            if (kick_cnt == '0) begin
              state     <= S_RAMP;
              osc_reset <= 1'b0;
              prescaler <= '0;
              tgt_ready <= 1'b1;
            end else begin
              kick_cnt <= kick_cnt - KW'(1);
            end
          end
          S_RAMP: begin
            if (step) begin
              prescaler <= '0;
              if (cur_code == tgt_eff) begin
                state  <= S_HOLD;
                busy   <= 1'b0;
                locked <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end
          S_HOLD: begin
            if (accept && tgt_clamped != cur_code) begin
              state     <= S_RAMP;
              prescaler <= '0;
              busy      <= 1'b1;
              locked    <= 1'b0;
            end
          end
          default: begin
            state <= S_OFF;
          end
        endcase
      end
    end
  end

endmodule
